threshold_ctrl: RTL
===================

// Module: threshold_ctrl
// PURPOSE
//  Per-frame adaptive threshold controller for the gray->binary stage.
//  - Accumulates gray sum and pixel count over each frame (i_de high).
//  - At the frame boundary it computes mean = sum/count with a sequential divider, then clamps the result.
//  - Commits the result to o_threshold, which drives the binariser's compare input.
//  - Manual mode bypasses the divider and commits i_th_manual instead.
// PARAMETERS
//  DW          8    gray / threshold width
//  CW          20   pixel-count width (max frame 2^CW-1 active pixels)
//  TH_DEFAULT  90   o_threshold after reset
//  TH_MIN      16   lower clamp for computed threshold
//  TH_MAX      240  upper clamp for computed threshold
// PORTS
//  pixelclk     in   1       single clock, all logic rising-edge
//  reset        in   1       asynchronous, active-high
//  i_gray       in   DW      gray pixel, valid when i_de=1
//  i_vsync      in   1       active-high vsync; rising edge = frame boundary
//  i_de         in   1       active-pixel qualifier
//  i_mode       in   1       0 = manual, 1 = adaptive; sampled at vsync rise
//  i_th_manual  in   DW      manual threshold; sampled at vsync rise
//  o_threshold  out  DW      committed threshold, stable between commits
//  o_th_valid   out  1       1-cycle pulse on the cycle o_threshold updates
//  o_busy       out  1       high while divide/clamp is in progress
//  o_overrun    out  1       1-cycle pulse: frame boundary dropped (divider busy)
// BEHAVIOUR
//  Reset
//  - o_threshold=TH_DEFAULT; o_th_valid=0; o_busy=0; o_overrun=0.
//  - Accumulators = 0; FSM = IDLE.
//  Accumulation (independent of FSM)
//  - Each cycle with i_de=1 and cnt!=all-ones: sum+=i_gray (sum width DW+CW), cnt+=1.
//  - When cnt is all-ones, both sum and cnt hold (saturate); no overflow is possible.
//  Vsync edge detect
//  - vs_d is a registered i_vsync; vs_rise = i_vsync & ~vs_d.
//  - On vs_rise: snapshot sum/cnt, and clear the accumulators in the same cycle.
//  - A pixel with i_de=1 in the vs_rise cycle is counted into the new frame.
//  FSM states: IDLE, DIV, CLAMP, COMMIT
//  - IDLE, vs_rise, i_mode=0: o_threshold<=i_th_manual, o_th_valid=1 next cycle; stay IDLE.
//  - IDLE, vs_rise, i_mode=1, snapshot cnt==0: no commit, no pulse; stay IDLE.
//  - IDLE, vs_rise, i_mode=1, cnt!=0: start divider -> DIV.
//  - DIV: divider iterates DW+CW cycles (one quotient bit per cycle); on done -> CLAMP.
//  - CLAMP: q_c = (q<TH_MIN) ? TH_MIN : (q>TH_MAX) ? TH_MAX : q[DW-1:0] -> COMMIT.
//  - COMMIT: o_threshold<=q_c, o_th_valid=1 for one cycle -> IDLE.
//  - Latency, adaptive mode: vs_rise to o_th_valid = DW+CW+3 cycles (31 at defaults).
//  - Vertical blanking must exceed this latency.
//  - Quotient is floor(sum/cnt); it never exceeds 2^DW-1, and the upper bits are zero.
//  Boundary conditions
//  - o_busy=1 in DIV, CLAMP and COMMIT.
//  - vs_rise while o_busy: accumulators still snapshot/clear, the new snapshot is discarded,
//    o_overrun pulses 1 cycle, and the in-flight divide completes and commits normally.
//  - vs_rise in the same cycle as COMMIT: treated as busy (overrun).
//  - Reset mid-divide: immediate return to reset values; no partial commit.
//  - i_mode / i_th_manual changes between vsync edges have no effect.
// STRUCTURE
//  Package threshold_pkg
//  - typedef enum {IDLE, DIV, CLAMP, COMMIT} th_state_t.
//  - Localparam SW = DW+CW (dividend width).
//  - Default TH_DEFAULT/TH_MIN/TH_MAX constants.
//  Sub-module seq_divider (restoring, unsigned)
//  - Ports: start, dividend[SW], divisor[CW], quotient[SW], done (1-cycle pulse).
//  - Reset is asynchronous and active-high.
//  Top level: edge detect, accumulators, FSM, clamp, output registers.
// TESTING
//  1 Reset: hold reset 5 cycles.
//    -> o_threshold=90, o_busy=0, no pulses.
//  2 Adaptive: 4x4 frame all gray=100, then vsync rise.
//    -> o_th_valid 31 cycles later, o_threshold=100.
//  3 Clamp:
//    a frame of all 5 -> o_threshold=16.
//    b frame of all 250 -> o_threshold=240.
//    c frame of 8 px {0,0,0,0,255,255,255,255} -> floor(1020/8)=127.
//  4 Empty / manual:
//    a vsync with no i_de -> no o_th_valid, threshold unchanged.
//    b i_mode=0, i_th_manual=77 at vsync rise -> o_threshold=77 next cycle, single pulse.
//  5 Overrun: second vsync rise 10 cycles after the first.
//    -> o_overrun pulses once, the first result still commits,
//       and the next frame's count excludes pixels before the second edge.
//  6 Mid-divide reset: assert reset 15 cycles into DIV.
//    -> o_threshold=90, FSM IDLE; the next frame computes correctly.

Source files
------------

// File: rtl/threshold_pkg.sv
// Shared types and default constants for the adaptive threshold controller.
// Widths here are the defaults; the top level re-derives them from its own parameters.
package threshold_pkg;

  localparam int TH_DW      = 8;
  localparam int TH_CW      = 20;
  localparam int TH_SW      = TH_DW + TH_CW;
  localparam int TH_DEF_VAL = 90;
  localparam int TH_MIN_VAL = 16;
  localparam int TH_MAX_VAL = 240;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    CLAMP  = 2'd2,
    COMMIT = 2'd3
  } th_state_t;

  // Cycles from the vsync rise to the o_th_valid pulse in adaptive mode.
  function automatic int adaptive_latency(input int dw, input int cw);
    return dw + cw + 3;
  endfunction

endpackage

// File: rtl/threshold_ctrl_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, SW cycles after i_start,
// then a single-cycle o_done pulse with the quotient held until the next start.
module seq_divider
  import threshold_pkg::*;
#(
  parameter int SW = TH_SW,
  parameter int CW = TH_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [SW-1:0] i_dividend,
  input  logic [CW-1:0] i_divisor,
  output logic [SW-1:0] o_quotient,
  output logic          o_done
);

  localparam int NW = $clog2(SW + 1);

  logic [SW-1:0] r_quo;
  logic [CW-1:0] r_rem;
  logic [CW-1:0] r_div;
  logic [NW-1:0] r_count;
  logic          r_done;

  logic [CW:0]   w_shift;
  logic [CW:0]   w_sub;
  logic          w_ge;

  // The partial remainder stays below the divisor, so CW+1 bits hold the shifted value.
  assign w_shift = {r_rem, r_quo[SW-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift - {1'b0, r_div};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo   <= i_dividend;
        r_rem   <= '0;
        r_div   <= i_divisor;
        r_count <= NW'(SW);
      end else if (r_count != '0) begin
        r_count <= r_count - NW'(1);
        r_quo   <= {r_quo[SW-2:0], w_ge};
        r_rem   <= w_ge ? w_sub[CW-1:0] : w_shift[CW-1:0];
        if (r_count == NW'(1)) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quotient = r_quo;
  assign o_done     = r_done;

endmodule

// File: rtl/threshold_ctrl.sv
// Per-frame adaptive threshold: accumulates gray sum/count, divides at the vsync rise,
// clamps the mean and commits it; manual mode commits i_th_manual directly.
module threshold_ctrl
  import threshold_pkg::*;
#(
  parameter int DW         = TH_DW,
  parameter int CW         = TH_CW,
  parameter int TH_DEFAULT = TH_DEF_VAL,
  parameter int TH_MIN     = TH_MIN_VAL,
  parameter int TH_MAX     = TH_MAX_VAL
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic [DW-1:0] i_gray,
  input  logic          i_vsync,
  input  logic          i_de,
  input  logic          i_mode,
  input  logic [DW-1:0] i_th_manual,
  output logic [DW-1:0] o_threshold,
  output logic          o_th_valid,
  output logic          o_busy,
  output logic          o_overrun
);

  localparam int SW = DW + CW;

  th_state_t     r_state;
  th_state_t     w_state_next;

  logic          r_vs_d;
  logic          w_vs_rise;
  logic [SW-1:0] r_sum;
  logic [CW-1:0] r_cnt;
  logic          w_cnt_full;

  logic          w_busy;
  logic          w_div_start;
  logic          w_load_manual;
  logic          w_load_calc;
  logic [SW-1:0] w_quo;
  logic          w_div_done;
  logic [DW-1:0] w_qc;

  logic [DW-1:0] r_threshold;
  logic          r_th_valid;
  logic          r_overrun;

  assign w_vs_rise  = i_vsync & ~r_vs_d;
  assign w_cnt_full = &r_cnt;

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_vs_d <= 1'b0;
    end else begin
      r_vs_d <= i_vsync;
    end
  end

  // The divider latches r_sum/r_cnt at start, which is the frame snapshot; the clear
  // happens on the same edge and a pixel in the rise cycle opens the new frame.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (w_vs_rise) begin
      r_sum <= i_de ? SW'(i_gray) : '0;
      r_cnt <= i_de ? CW'(1) : '0;
    end else if (i_de && !w_cnt_full) begin
      r_sum <= r_sum + SW'(i_gray);
      r_cnt <= r_cnt + CW'(1);
    end
  end

  seq_divider #(
    .SW (SW),
    .CW (CW)
  ) u_divider (
    .clk        (pixelclk),
    .rst        (reset),
    .i_start    (w_div_start),
    .i_dividend (r_sum),
    .i_divisor  (r_cnt),
    .o_quotient (w_quo),
    .o_done     (w_div_done)
  );

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_vs_rise && i_mode && (r_cnt != '0)) w_state_next = DIV;
      DIV:     if (w_div_done) w_state_next = CLAMP;
      CLAMP:   w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy        = (r_state != IDLE);
    w_div_start   = (r_state == IDLE) && w_vs_rise && i_mode && (r_cnt != '0);
    w_load_manual = (r_state == IDLE) && w_vs_rise && !i_mode;
    w_load_calc   = (r_state == CLAMP);
  end

  // The quotient of an 8-bit mean never exceeds DW bits, but the full width is compared anyway.
  assign w_qc = (w_quo < SW'(TH_MIN)) ? DW'(TH_MIN) :
                (w_quo > SW'(TH_MAX)) ? DW'(TH_MAX) : w_quo[DW-1:0];

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_threshold <= DW'(TH_DEFAULT);
      r_th_valid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_th_valid <= w_load_manual | w_load_calc;
      r_overrun  <= w_vs_rise & w_busy;
      if (w_load_manual) begin
        r_threshold <= i_th_manual;
      end else if (w_load_calc) begin
        r_threshold <= w_qc;
      end
    end
  end

  assign o_threshold = r_threshold;
  assign o_th_valid  = r_th_valid;
  assign o_busy      = w_busy;
  assign o_overrun   = r_overrun;

endmodule
